// File: rtl/imem_boot_ctrl.sv
// Boot sequencer and port arbiter for the single-port instruction memory.
// Owns imem while a host streams an image in, then hands the port to fetch.
module imem_boot_ctrl #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int DRAIN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_last,
  output logic              host_ready,
  input  logic              host_boot,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_address,
  output logic [DATA_W-1:0] imem_data,
  output logic              imem_rden,
  output logic              imem_wren,
  output logic              cpu_run,
  output logic              pc_write_gate,
  output logic [ADDR_W:0]   load_count,
  output logic              load_err
);

  // state | meaning
  // BOOT  | host owns imem, core idle, beats written sequentially
  // START | one-cycle prefetch of word 0
  // RUN   | fetch owns imem, core released
  // HALT  | core frozen while in-flight fetches drain
  typedef enum logic [1:0] {S_BOOT, S_START, S_RUN, S_HALT} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W:0]   r_load_count;
  logic              r_load_err;
  logic [2:0]        r_drain;
  logic              w_full;
  logic              w_beat;
  logic              w_boot_entry;

  assign w_full       = r_load_count[ADDR_W];
  assign w_boot_entry = (r_state == S_HALT) && (w_next == S_BOOT);
  assign imem_data    = host_data;
  assign load_count   = r_load_count;
  assign load_err     = r_load_err;

  always_comb begin
    w_next        = r_state;
    host_ready    = 1'b0;
    imem_address  = '0;
    imem_rden     = 1'b0;
    imem_wren     = 1'b0;
    cpu_run       = 1'b0;
    pc_write_gate = 1'b0;
    w_beat        = 1'b0;
    case (r_state)
      S_BOOT: begin
        host_ready = 1'b1;
        w_beat     = host_valid;
        // A full image still accepts beats so the host can finish; they are dropped.
        if (host_valid && !w_full) begin
          imem_wren    = 1'b1;
          imem_address = r_load_count[ADDR_W-1:0];
        end
        if (host_valid && host_last) w_next = S_START;
      end
      S_START: begin
        imem_rden = 1'b1;
        w_next    = S_RUN;
      end
      S_RUN: begin
        imem_address  = pc_addr;
        imem_rden     = fetch_en;
        cpu_run       = 1'b1;
        pc_write_gate = 1'b1;
        if (host_boot) w_next = S_HALT;
      end
      S_HALT: begin
        if (r_drain == 3'd0) w_next = S_BOOT;
      end
      default: w_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_BOOT;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load_count <= '0;
      r_load_err   <= 1'b0;
    end else if (w_boot_entry) begin
      r_load_count <= '0;
      r_load_err   <= 1'b0;
    end else if (w_beat) begin
      if (w_full) r_load_err   <= 1'b1;
      else        r_load_count <= r_load_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drain <= 3'd0;
    end else if ((r_state == S_RUN) && (w_next == S_HALT)) begin
      r_drain <= 3'(DRAIN_CYC - 1);
    end else if ((r_state == S_HALT) && (r_drain != 3'd0)) begin
      r_drain <= r_drain - 3'd1;
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: expected imem writes are queued by the
// stimulus and popped by an independent monitor whenever the DUT writes.
module tb_imem_boot_ctrl;
  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int DC    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          host_valid;
  logic [DW-1:0] host_data;
  logic          host_last;
  logic          host_ready;
  logic          host_boot;
  logic [AW-1:0] pc_addr;
  logic          fetch_en;
  logic [AW-1:0] imem_address;
  logic [DW-1:0] imem_data;
  logic          imem_rden;
  logic          imem_wren;
  logic          cpu_run;
  logic          pc_write_gate;
  logic [AW:0]   load_count;
  logic          load_err;

  imem_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DRAIN_CYC(DC)) dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_data(host_data), .host_last(host_last),
    .host_ready(host_ready), .host_boot(host_boot),
    .pc_addr(pc_addr), .fetch_en(fetch_en),
    .imem_address(imem_address), .imem_data(imem_data),
    .imem_rden(imem_rden), .imem_wren(imem_wren),
    .cpu_run(cpu_run), .pc_write_gate(pc_write_gate),
    .load_count(load_count), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  m_count;
  bit  m_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: every imem write must match the next queued expectation
  always @(negedge clk) begin
    if (rst) begin
      chk("wr_rd_overlap", {62'd0, imem_wren, imem_rden} == 64'd3, 64'd0);
      if (imem_wren) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {32'd0, 29'd0, imem_address}, 64'hFFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", imem_address, e.a);
          chk("wr_data", imem_data, e.d);
        end
      end
    end
  end

  task automatic idle_cycle();
    host_valid = 1'b0;
    host_data  = $urandom;
    host_last  = 1'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [DW-1:0] d, input bit last);
    host_valid = 1'b1;
    host_data  = d;
    host_last  = last;
    if (m_count < DEPTH) begin
      exp_q.push_back('{a: AW'(m_count), d: d});
      m_count++;
    end else begin
      m_err = 1'b1;
    end
    @(negedge clk);
    chk("boot_ready", host_ready, 1);
    chk("boot_cpu_run", cpu_run, 0);
    @(posedge clk); #1;
    host_valid = 1'b0;
    host_last  = 1'b0;
  endtask

  // gap: 0 back-to-back, 1 idle before every beat, 2 random idles
  task automatic load(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (gap == 1) idle_cycle();
      else if (gap == 2) repeat ($urandom_range(0, 2)) idle_cycle();
      beat($urandom, i == n - 1);
    end
  endtask

  task automatic end_of_load();
    @(negedge clk);
    chk("start_ready", host_ready, 0);
    chk("start_rden", imem_rden, 1);
    chk("start_addr", imem_address, 0);
    chk("start_cpu_run", cpu_run, 0);
    chk("load_count", load_count, m_count);
    chk("load_err", load_err, m_err);
    chk("writes_done", exp_q.size(), 0);
    @(negedge clk);
    chk("run_cpu_run", cpu_run, 1);
    chk("run_gate", pc_write_gate, 1);
  endtask

  task automatic run_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      pc_addr  = AW'($urandom);
      fetch_en = 1'($urandom);
      @(negedge clk);
      chk("run_addr", imem_address, pc_addr);
      chk("run_rden", imem_rden, fetch_en);
      chk("run_wren", imem_wren, 0);
      chk("run_cpu_run", cpu_run, 1);
    end
  endtask

  // entered at the first negedge inside HALT
  task automatic drain_check();
    int c;
    chk("halt_cpu_run", cpu_run, 0);
    chk("halt_gate", pc_write_gate, 0);
    chk("halt_rden", imem_rden, 0);
    c = 0;
    while (host_ready === 1'b0 && c < 20) begin
      c++;
      @(negedge clk);
    end
    chk("drain_cycles", c, DC);
    m_count = 0;
    m_err   = 1'b0;
    chk("boot_count_clr", load_count, 0);
    chk("boot_err_clr", load_err, 0);
    chk("boot_cpu_run", cpu_run, 0);
  endtask

  task automatic halt();
    @(posedge clk); #1;
    host_boot = 1'b1;
    @(negedge clk);
    chk("pre_halt_run", cpu_run, 1);
    @(posedge clk); #1;
    host_boot = 1'b0;
    @(negedge clk);
    drain_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; host_valid = 1'b0; host_data = '0; host_last = 1'b0;
    host_boot = 1'b0; pc_addr = '0; fetch_en = 1'b0;
    m_count = 0; m_err = 1'b0;
    #2;
    chk("rst_ready", host_ready, 1);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_gate", pc_write_gate, 0);
    chk("rst_rden", imem_rden, 0);
    chk("rst_wren", imem_wren, 0);
    chk("rst_addr", imem_address, 0);
    chk("rst_count", load_count, 0);
    chk("rst_err", load_err, 0);
    #21 rst = 1'b1;
    @(posedge clk); #1;

    // directed 4-beat image
    for (int i = 0; i < 4; i++) beat(32'hA0 + i, i == 3);
    end_of_load();
    run_cycles(5);
    halt();

    // valid toggled every other cycle
    @(posedge clk); #1;
    load(5, 1);
    end_of_load();
    run_cycles(3);
    halt();

    // overflow: 9 beats into 8 words
    @(posedge clk); #1;
    load(9, 0);
    end_of_load();
    run_cycles(2);
    halt();

    // reset mid-load restarts at address 0
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) beat($urandom, 1'b0);
    #1 rst = 1'b0;
    m_count = 0; m_err = 1'b0;
    #1;
    chk("midrst_count", load_count, 0);
    chk("midrst_ready", host_ready, 1);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) beat($urandom, 1'b0);
    @(negedge clk);
    chk("midrst_count2", load_count, 2);
    @(posedge clk); #1;
    beat($urandom, 1'b1);
    end_of_load();
    halt();

    // host_boot held across the load: one RUN cycle then HALT
    @(posedge clk); #1;
    host_boot = 1'b1;
    load(3, 2);
    end_of_load();
    @(posedge clk); #1;
    host_boot = 1'b0;
    @(negedge clk);
    drain_check();

    // randomized images
    for (int it = 0; it < 8; it++) begin
      @(posedge clk); #1;
      load($urandom_range(1, 11), $urandom_range(0, 2));
      end_of_load();
      run_cycles($urandom_range(1, 4));
      halt();
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
